// File: rtl/mips_reg_display_pkg.sv
// Shared constants, types and the active-high hex-to-7-segment glyph table
// used by the register display and any other 7-segment users.
package mips_reg_display_pkg;

    localparam int REG_ID_W    = 5;
    localparam int DATA_W      = 32;
    localparam int DIGIT_W     = 4;
    localparam int NUM_DIGITS  = DATA_W / DIGIT_W;
    localparam int DIGIT_IDX_W = $clog2(NUM_DIGITS);

    typedef logic [REG_ID_W-1:0]    reg_id_t;
    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;
    typedef logic [6:0]             seg_t;      // {g,f,e,d,c,b,a}

    // Active-high glyphs; callers invert for common-anode displays.
    function automatic seg_t hex_to_seg(input logic [DIGIT_W-1:0] nib);
        seg_t glyph;
        case (nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            4'hF:    glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/mips_reg_display_if.sv
// Register-inspection link to the core plus the multiplexed 7-segment outputs.
// master = display front end, slave = core/board side.
interface mips_reg_display_if;
    import mips_reg_display_pkg::*;

    reg_id_t                 reg_out_id;
    logic [DATA_W-1:0]       reg_out_data;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    dp;

    modport master (output reg_out_id, an, seg, dp, input reg_out_data);
    modport slave  (input reg_out_id, an, seg, dp, output reg_out_data);
endinterface

// File: rtl/mips_reg_display_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on an accepted press (release produces no pulse).
module mips_reg_display_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then accept a new level only after it has been stable long enough.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= CNT_ZERO;
                level_r <= sync2_r;
                rise_r  <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign rise = rise_r;
endmodule

// File: rtl/mips_reg_display.sv
// Register selector and 8-digit hex scanner for the core's register-inspection port.
// Buttons step the selected register; a snapshot of its value is scanned onto the display.
module mips_reg_display
    import mips_reg_display_pkg::*;
#(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 hold,
    mips_reg_display_if.master   bus
);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [REF_W-1:0] REF_ONE   = REF_W'(1);
    localparam logic [REF_W-1:0] REF_ZERO  = REF_W'(0);
    localparam reg_id_t          ID_ONE    = REG_ID_W'(1);
    localparam digit_idx_t       IDX_ONE   = DIGIT_IDX_W'(1);
    localparam digit_idx_t       IDX_LAST  = DIGIT_IDX_W'(NUM_DIGITS - 1);
    localparam digit_idx_t       IDX_ZERO  = DIGIT_IDX_W'(0);

    logic                  next_pulse_s;
    logic                  prev_pulse_s;
    logic                  hold_sync1_r;
    logic                  hold_sync2_r;
    reg_id_t               reg_id_r;
    reg_id_t               prev_id_r;
    reg_id_t               id_next_s;
    logic [DATA_W-1:0]     snapshot_r;
    logic [REF_W-1:0]      ref_cnt_r;
    digit_idx_t            digit_idx_r;
    logic                  ref_tc_s;
    logic                  load_snap_s;
    logic [DIGIT_W-1:0]    nibble_s;
    logic [NUM_DIGITS-1:0] an_r;
    seg_t                  seg_r;
    logic                  dp_r;

    mips_reg_display_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clock(clock), .reset(reset), .btn_raw(btn_next), .rise(next_pulse_s)
    );
    mips_reg_display_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clock(clock), .reset(reset), .btn_raw(btn_prev), .rise(prev_pulse_s)
    );

    assign ref_tc_s = (ref_cnt_r == REF_LAST);
    // A changed id reloads regardless of hold; a scan wrap reloads only when not held.
    assign load_snap_s = (prev_id_r != reg_id_r) ||
                         (ref_tc_s && (digit_idx_r == IDX_LAST) && !hold_sync2_r);

    // Next register index; simultaneous presses cancel out.
    always_comb begin
        id_next_s = reg_id_r;
        if (next_pulse_s && !prev_pulse_s) begin
            id_next_s = reg_id_r + ID_ONE;
        end else if (prev_pulse_s && !next_pulse_s) begin
            id_next_s = reg_id_r - ID_ONE;
        end else begin
            id_next_s = reg_id_r;
        end
    end

    // Nibble of the snapshot belonging to the currently scanned digit.
    always_comb begin
        nibble_s = snapshot_r[{digit_idx_r, 2'b00} +: DIGIT_W];
    end

    // Selection, snapshot, hold synchronizer and scan counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_sync1_r <= 1'b0;
            hold_sync2_r <= 1'b0;
            reg_id_r     <= {REG_ID_W{1'b0}};
            prev_id_r    <= {REG_ID_W{1'b0}};
            snapshot_r   <= {DATA_W{1'b0}};
            ref_cnt_r    <= REF_ZERO;
            digit_idx_r  <= IDX_ZERO;
        end else begin
            hold_sync1_r <= hold;
            hold_sync2_r <= hold_sync1_r;
            reg_id_r     <= id_next_s;
            prev_id_r    <= reg_id_r;
            if (load_snap_s) begin
                snapshot_r <= bus.reg_out_data;
            end else begin
                snapshot_r <= snapshot_r;
            end
            if (ref_tc_s) begin
                ref_cnt_r   <= REF_ZERO;
                digit_idx_r <= digit_idx_r + IDX_ONE;
            end else begin
                ref_cnt_r   <= ref_cnt_r + REF_ONE;
                digit_idx_r <= digit_idx_r;
            end
        end
    end

    // Display drivers, registered one cycle behind the digit index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_r);
            seg_r <= ~hex_to_seg(nibble_s);
            dp_r  <= ~(hold_sync2_r && (digit_idx_r == IDX_ZERO));
        end
    end

    assign bus.reg_out_id = reg_id_r;
    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
endmodule

// File: tb/tb_mips_reg_display.sv
// Directed-plus-random bench for mips_reg_display with a small core register-file model
// and an expected display derived from the selected register's value.
module tb_mips_reg_display;
    localparam int REFRESH_DIV     = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int NUM_DIG         = 8;
    localparam int SCAN            = NUM_DIG * REFRESH_DIV;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        hold     = 1'b0;
    logic [31:0] regs [32];
    logic [4:0]  exp_id;
    logic [31:0] rnd_val;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ncyc     = 0;

    // Active-high glyphs {g,f,e,d,c,b,a} for 0..F
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    mips_reg_display_if bus();
    assign bus.reg_out_data = regs[bus.reg_out_id];

    mips_reg_display #(.REFRESH_DIV(REFRESH_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
        .clock(clock), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .hold(hold), .bus(bus)
    );

    always #5 clock = ~clock;

    // Cycles elapsed since the last reset release
    always @(posedge clock or negedge reset) begin
        if (!reset) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input bit nxt, input bit prv, input int len);
        btn_next = nxt;
        btn_prev = prv;
        tick(len);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(20);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_id"},  32'(bus.reg_out_id), 32'd0);
        check({tag, "_an"},  32'(bus.an),  32'hFF);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_dp"},  32'(bus.dp),  32'd1);
    endtask

    // One full scan: digit order/dwell from elapsed cycles, glyph from the expected value
    task automatic scan_check(input string tag, input logic [31:0] val, input bit hold_exp);
        int         idx;
        logic [7:0] an_exp;
        logic [6:0] seg_exp;
        logic [3:0] nib;
        for (int i = 0; i < SCAN; i++) begin
            tick(1);
            idx     = ((ncyc - 1) / REFRESH_DIV) % NUM_DIG;
            an_exp  = ~(8'b1 << idx);
            nib     = val[4*idx +: 4];
            seg_exp = ~glyph[nib];
            check({tag, "_an"},  32'(bus.an),  32'(an_exp));
            check({tag, "_seg"}, 32'(bus.seg), 32'(seg_exp));
            check({tag, "_dp"},  32'(bus.dp),  (hold_exp && idx == 0) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        int lat;
        bit found;
        int len;
        foreach (regs[i]) regs[i] = $urandom;
        exp_id = 5'd0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset_outputs("reset_hold");
        end
        reset = 1'b1;
        tick(2);
        check("post_reset_id", 32'(bus.reg_out_id), 32'd0);

        // Press latency: 2 sync + DEBOUNCE_CYCLES + 1
        btn_next = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            tick(1);
            if (bus.reg_out_id != 5'd0) begin
                found = 1'b1;
                lat = c;
            end
        end
        check("press_latency", 32'(lat), 32'd11);
        check("press_id", 32'(bus.reg_out_id), 32'd1);
        tick(20 - lat);
        check("long_press_once", 32'(bus.reg_out_id), 32'd1);
        btn_next = 1'b0;
        tick(20);
        check("release_no_step", 32'(bus.reg_out_id), 32'd1);
        exp_id = 5'd1;

        // Glitches shorter than the debounce window
        press(1'b1, 1'b0, 5);
        check("glitch_next", 32'(bus.reg_out_id), 32'(exp_id));
        press(1'b0, 1'b1, $urandom_range(1, 6));
        check("glitch_prev", 32'(bus.reg_out_id), 32'(exp_id));

        // Wrap in both directions and simultaneous presses
        press(1'b0, 1'b1, 12);
        check("prev_to_0", 32'(bus.reg_out_id), 32'd0);
        press(1'b0, 1'b1, 12);
        check("prev_wrap_31", 32'(bus.reg_out_id), 32'd31);
        press(1'b1, 1'b0, 12);
        check("next_wrap_0", 32'(bus.reg_out_id), 32'd0);
        press(1'b1, 1'b1, 12);
        check("both_no_change", 32'(bus.reg_out_id), 32'd0);
        exp_id = 5'd0;

        // Random walk over the register index
        repeat (8) begin
            len = $urandom_range(9, 16);
            if ($urandom_range(0, 1) == 1) begin
                press(1'b1, 1'b0, len);
                exp_id = exp_id + 5'd1;
            end else begin
                press(1'b0, 1'b1, len);
                exp_id = exp_id - 5'd1;
            end
            check("random_walk_id", 32'(bus.reg_out_id), 32'(exp_id));
        end

        // Live display of a known value
        hold = 1'b0;
        regs[exp_id] = 32'h1234ABCD;
        tick(40);
        scan_check("scan_live", 32'h1234ABCD, 1'b0);

        // Hold freezes the display; releasing it picks up the new value
        hold = 1'b1;
        tick(4);
        regs[exp_id] = 32'h0;
        tick(40);
        scan_check("scan_held", 32'h1234ABCD, 1'b1);
        hold = 1'b0;
        tick(40);
        scan_check("scan_zero", 32'h0, 1'b0);

        // Register change reloads the snapshot even while held
        hold = 1'b1;
        tick(4);
        rnd_val = $urandom;
        regs[exp_id + 5'd1] = rnd_val;
        press(1'b1, 1'b0, 12);
        exp_id = exp_id + 5'd1;
        check("held_next_id", 32'(bus.reg_out_id), 32'(exp_id));
        tick(5);
        scan_check("scan_reload", rnd_val, 1'b1);

        // Asynchronous reset in the middle of a digit
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset_outputs("async_reset_hold");
        end
        reset = 1'b1;
        hold = 1'b0;
        tick(2);
        check("after_async_id", 32'(bus.reg_out_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
